// File: rtl/hc4_ram_pkg.sv
// rtl/hc4_ram_pkg.sv - default widths and shared enums for the nibble RAM arbiter
package hc4_ram_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } arb_state_t;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } arb_port_t;

endpackage

// File: rtl/ram_arb_grant.sv
// rtl/ram_arb_grant.sv - port selection; RAM_ARB_ROUND_ROBIN_EN selects round-robin
// over fixed A-priority on contention
module ram_arb_grant
  import hc4_ram_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      a_req,
  input  logic      b_req,
  input  logic      take,
  output arb_port_t grant
);

`ifdef RAM_ARB_ROUND_ROBIN_EN
  // Starts as "B last" so the first contention after reset goes to A.
  arb_port_t last_grant;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= PORT_B;
    end else if (take) begin
      last_grant <= grant;
    end
  end

  always_comb begin
    grant = PORT_A;
    if (a_req && b_req) begin
      grant = (last_grant == PORT_A) ? PORT_B : PORT_A;
    end else if (b_req) begin
      grant = PORT_B;
    end
  end
`else
  logic unused_grant_inputs;
  assign unused_grant_inputs = clk ^ rst ^ take;

  always_comb begin
    grant = PORT_A;
    if (b_req && !a_req) begin
      grant = PORT_B;
    end
  end
`endif

endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - two-port arbiter in front of a single nibble RAM; three-cycle
// IDLE/ACCESS/ACK access; RAM_ARB_ROUND_ROBIN_EN enables round-robin contention
module ram_arbiter
  import hc4_ram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic [DATA_W-1:0] b_rdata,
  output logic [ADDR_W-1:0] mem_address,
  inout  wire  [DATA_W-1:0] mem_data,
  output logic              mem_write_enable,
  output logic              mem_read_enable
);

  arb_state_t        state, state_nxt;
  arb_port_t         grant, gnt_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              take;

  assign take = (state == IDLE) && (a_req || b_req);

  ram_arb_grant u_grant (
    .clk   (clk),
    .rst   (rst),
    .a_req (a_req),
    .b_req (b_req),
    .take  (take),
    .grant (grant)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (a_req || b_req) state_nxt = ACCESS;
      ACCESS:  state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request fields are captured once so the requester's later changes cannot disturb the access.
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_q   <= PORT_A;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (take) begin
      gnt_q   <= grant;
      we_q    <= (grant == PORT_B) ? b_we    : a_we;
      addr_q  <= (grant == PORT_B) ? b_addr  : a_addr;
      wdata_q <= (grant == PORT_B) ? b_wdata : a_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_rdata <= '0;
      b_rdata <= '0;
    end else if (state == ACCESS && !we_q) begin
      if (gnt_q == PORT_B) begin
        b_rdata <= mem_data;
      end else begin
        a_rdata <= mem_data;
      end
    end
  end

  always_comb begin
    mem_address      = '0;
    mem_write_enable = 1'b0;
    mem_read_enable  = 1'b0;
    a_ack            = 1'b0;
    b_ack            = 1'b0;
    if (state == ACCESS) begin
      mem_address      = addr_q;
      mem_write_enable = we_q;
      mem_read_enable  = !we_q;
    end
    if (state == ACK) begin
      a_ack = (gnt_q == PORT_A);
      b_ack = (gnt_q == PORT_B);
    end
  end

  assign mem_data = (state == ACCESS && we_q) ? wdata_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - self-checking bench for ram_arbiter against a transaction-level model
module tb_ram_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       a_req, a_we, b_req, b_we;
  logic [7:0] a_addr, b_addr;
  logic [3:0] a_wdata, b_wdata;
  logic       a_ack, b_ack;
  logic [3:0] a_rdata, b_rdata;
  logic [7:0] mem_address;
  wire  [3:0] mem_data;
  logic       mem_write_enable, mem_read_enable;

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0] ram       [256] = '{default: 4'h0};
  logic [3:0] model_mem [256] = '{default: 4'h0};
  logic [3:0] exp_a_rd = 4'h0;
  logic [3:0] exp_b_rd = 4'h0;
  logic       last_a_model = 1'b0;

  always #5 clk = ~clk;

  ram_arbiter #(.ADDR_W(8), .DATA_W(4)) dut (
    .clk              (clk),
    .rst              (rst),
    .a_req            (a_req),
    .a_we             (a_we),
    .a_addr           (a_addr),
    .a_wdata          (a_wdata),
    .a_ack            (a_ack),
    .a_rdata          (a_rdata),
    .b_req            (b_req),
    .b_we             (b_we),
    .b_addr           (b_addr),
    .b_wdata          (b_wdata),
    .b_ack            (b_ack),
    .b_rdata          (b_rdata),
    .mem_address      (mem_address),
    .mem_data         (mem_data),
    .mem_write_enable (mem_write_enable),
    .mem_read_enable  (mem_read_enable)
  );

  // Memory device; the bus is parked at 0 when nobody should drive it, so a stray drive shows up.
  assign mem_data = mem_read_enable ? ram[mem_address] : 4'bz;
  assign mem_data = (!mem_read_enable && !mem_write_enable) ? 4'h0 : 4'bz;

  always @(posedge clk) begin
    if (mem_write_enable) ram[mem_address] <= mem_data;
  end

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive_a(input logic req, input logic we, input logic [7:0] addr, input logic [3:0] wd);
    a_req = req; a_we = we; a_addr = addr; a_wdata = wd;
  endtask

  task automatic drive_b(input logic req, input logic we, input logic [7:0] addr, input logic [3:0] wd);
    b_req = req; b_we = we; b_addr = addr; b_wdata = wd;
  endtask

  // Arbitration rule: a lone requester wins; on contention fixed mode picks A, round-robin the port not last served.
  function automatic logic pick_b(input logic ra, input logic rb);
    if (ra && rb) begin
`ifdef RAM_ARB_ROUND_ROBIN_EN
      return last_a_model;
`else
      return 1'b0;
`endif
    end
    return rb && !ra;
  endfunction

  // Called in an IDLE cycle with requests already driven; walks ACCESS and ACK of the expected winner.
  task automatic serve(input string name, input logic exp_b);
    logic       we;
    logic [7:0] addr;
    logic [3:0] wd;
    we   = exp_b ? b_we    : a_we;
    addr = exp_b ? b_addr  : a_addr;
    wd   = exp_b ? b_wdata : a_wdata;
    n_checks++;
    if ({mem_write_enable, mem_read_enable} !== 2'b00 || mem_data !== 4'h0) begin
      n_fail++;
      $display("FAIL %s idle_bus: en=%b data=%h, want en=00 data=0 (undriven)", name,
               {mem_write_enable, mem_read_enable}, mem_data);
    end
    tick;
    n_checks++;
    if (mem_address !== addr) begin
      n_fail++;
      $display("FAIL %s access_addr: got %h want %h", name, mem_address, addr);
    end
    n_checks++;
    if ({mem_write_enable, mem_read_enable} !== {we, !we}) begin
      n_fail++;
      $display("FAIL %s access_en: got %b want %b", name, {mem_write_enable, mem_read_enable}, {we, !we});
    end
    if (we) begin
      n_checks++;
      if (mem_data !== wd) begin
        n_fail++;
        $display("FAIL %s write_data: got %h want %h", name, mem_data, wd);
      end
    end
    n_checks++;
    if ({a_ack, b_ack} !== 2'b00) begin
      n_fail++;
      $display("FAIL %s early_ack: got %b want 00", name, {a_ack, b_ack});
    end
    tick;
    n_checks++;
    if ({a_ack, b_ack} !== {!exp_b, exp_b}) begin
      n_fail++;
      $display("FAIL %s ack: got a,b=%b want %b", name, {a_ack, b_ack}, {!exp_b, exp_b});
    end
    n_checks++;
    if ({mem_write_enable, mem_read_enable, mem_address} !== 10'h0 || mem_data !== 4'h0) begin
      n_fail++;
      $display("FAIL %s ack_bus: en=%b addr=%h data=%h, want all inactive", name,
               {mem_write_enable, mem_read_enable}, mem_address, mem_data);
    end
    if (we) model_mem[addr] = wd;
    else if (exp_b) exp_b_rd = model_mem[addr];
    else exp_a_rd = model_mem[addr];
    n_checks++;
    if (a_rdata !== exp_a_rd || b_rdata !== exp_b_rd) begin
      n_fail++;
      $display("FAIL %s rdata: got a=%h b=%h want a=%h b=%h", name, a_rdata, b_rdata, exp_a_rd, exp_b_rd);
    end
    last_a_model = !exp_b;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick;
    tick;
    n_checks++;
    if ({a_ack, b_ack, mem_write_enable, mem_read_enable} !== 4'b0 || mem_address !== 8'h00 ||
        a_rdata !== 4'h0 || b_rdata !== 4'h0 || mem_data !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_state: acks=%b en=%b addr=%h rd=%h/%h data=%h, want all 0",
               {a_ack, b_ack}, {mem_write_enable, mem_read_enable}, mem_address, a_rdata, b_rdata, mem_data);
    end
    rst = 1'b0;
    tick;
  endtask

  task automatic test_write_read_a;
    drive_a(1'b1, 1'b1, 8'h0A, 4'hA);
    serve("a_wr_0a", pick_b(1'b1, 1'b0));
    a_req = 1'b0;
    tick;
    drive_a(1'b1, 1'b0, 8'h0A, 4'h0);
    serve("a_rd_0a", pick_b(1'b1, 1'b0));
    a_req = 1'b0;
    n_checks++;
    if (a_rdata !== 4'hA) begin
      n_fail++;
      $display("FAIL a_rd_0a_value: got %h want a", a_rdata);
    end
    tick;
  endtask

  task automatic test_contention;
    logic first;
    drive_a(1'b1, 1'b1, 8'h10, 4'h3);
    drive_b(1'b1, 1'b1, 8'h11, 4'h5);
    first = pick_b(1'b1, 1'b1);
    serve("cont_first", first);
    if (first) b_req = 1'b0; else a_req = 1'b0;
    tick;
    serve("cont_second", !first);
    a_req = 1'b0; b_req = 1'b0;
    tick;
    drive_a(1'b1, 1'b0, 8'h10, 4'h0);
    serve("cont_rd_a", pick_b(1'b1, 1'b0));
    a_req = 1'b0;
    tick;
    drive_b(1'b1, 1'b0, 8'h11, 4'h0);
    serve("cont_rd_b", pick_b(1'b0, 1'b1));
    b_req = 1'b0;
    n_checks++;
    if ({a_rdata, b_rdata} !== 8'h35) begin
      n_fail++;
      $display("FAIL cont_values: got a=%h b=%h want a=3 b=5", a_rdata, b_rdata);
    end
    tick;
  endtask

  task automatic test_hold_both;
    drive_a(1'b1, 1'b1, 8'h20, 4'h6);
    drive_b(1'b1, 1'b1, 8'h21, 4'h9);
    for (int i = 0; i < 6; i++) begin
      serve($sformatf("hold%0d", i), pick_b(1'b1, 1'b1));
      if (i != 5) tick;
    end
    a_req = 1'b0; b_req = 1'b0;
    tick;
  endtask

  task automatic test_wrap_b;
    drive_b(1'b1, 1'b1, 8'hFF, 4'hF);
    serve("b_wr_ff", pick_b(1'b0, 1'b1));
    b_req = 1'b0;
    tick;
    drive_b(1'b1, 1'b0, 8'hFF, 4'h0);
    serve("b_rd_ff", pick_b(1'b0, 1'b1));
    b_req = 1'b0;
    n_checks++;
    if (b_rdata !== 4'hF) begin
      n_fail++;
      $display("FAIL b_rd_ff_value: got %h want f", b_rdata);
    end
    tick;
  endtask

  task automatic test_reset_mid;
    drive_a(1'b1, 1'b0, 8'h11, 4'h0);
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    a_req = 1'b0;
    exp_a_rd = 4'h0; exp_b_rd = 4'h0; last_a_model = 1'b0;
    n_checks++;
    if ({a_ack, b_ack, mem_write_enable, mem_read_enable} !== 4'b0 || a_rdata !== 4'h0 || b_rdata !== 4'h0) begin
      n_fail++;
      $display("FAIL rst_in_access: acks=%b en=%b rd=%h/%h want all 0",
               {a_ack, b_ack}, {mem_write_enable, mem_read_enable}, a_rdata, b_rdata);
    end
    tick;
    n_checks++;
    if ({a_ack, b_ack, mem_write_enable, mem_read_enable} !== 4'b0 || mem_address !== 8'h00) begin
      n_fail++;
      $display("FAIL rst_in_access_after: acks=%b en=%b addr=%h want all 0",
               {a_ack, b_ack}, {mem_write_enable, mem_read_enable}, mem_address);
    end
    drive_b(1'b1, 1'b0, 8'hFF, 4'h0);
    tick;
    tick;
    n_checks++;
    if ({b_ack, b_rdata} !== 5'h1F) begin
      n_fail++;
      $display("FAIL rst_in_ack_pre: b_ack=%b b_rdata=%h want 1 f", b_ack, b_rdata);
    end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    b_req = 1'b0;
    n_checks++;
    if ({a_ack, b_ack} !== 2'b00 || b_rdata !== 4'h0) begin
      n_fail++;
      $display("FAIL rst_in_ack: acks=%b b_rdata=%h want 00 0", {a_ack, b_ack}, b_rdata);
    end
    tick;
  endtask

  task automatic test_random;
    int   mode;
    logic ra, rb, first;
    for (int i = 0; i < 40; i++) begin
      mode = $urandom_range(0, 2);
      ra = (mode != 1);
      rb = (mode != 0);
      drive_a(ra, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)), 4'($urandom_range(1, 15)));
      drive_b(rb, 1'($urandom_range(0, 1)), (i % 9 == 0) ? 8'hFF : 8'($urandom_range(0, 7)),
              4'($urandom_range(1, 15)));
      first = pick_b(ra, rb);
      serve($sformatf("rnd%0d_first", i), first);
      if (first) b_req = 1'b0; else a_req = 1'b0;
      tick;
      if (ra && rb) begin
        serve($sformatf("rnd%0d_second", i), !first);
        a_req = 1'b0; b_req = 1'b0;
        tick;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    drive_a(1'b0, 1'b0, 8'h00, 4'h0);
    drive_b(1'b0, 1'b0, 8'h00, 4'h0);
    @(negedge clk);
    test_reset;
    test_write_read_a;
    test_contention;
    test_hold_both;
    test_wrap_b;
    test_reset_mid;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
